// File: rtl/fe_capture_sequencer_if.sv
// FIFO write bus between the capture sequencer and the FIFO write stage.
interface fe_capture_sequencer_if #(
  parameter int pTIMESTAMP_FULL_WIDTH = 16
);
  logic                             fifo_wr;
  logic [1:0]                       fifo_command;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] fifo_time;
  logic                             fifo_full;

  modport master (output fifo_wr, fifo_command, fifo_time, input fifo_full);
  modport slave  (input fifo_wr, fifo_command, fifo_time, output fifo_full);
endinterface

// File: rtl/fe_capture_sequencer.sv
// Front-end capture sequencer: arm/trigger/stop control, inter-event delta
// timing, TIME-entry insertion for long gaps, length limiting and overflow.
`ifndef FE_FIFO_CMD_DATA
`define FE_FIFO_CMD_DATA 2'b00
`define FE_FIFO_CMD_STAT 2'b01
`define FE_FIFO_CMD_TIME 2'b10
`endif

module fe_capture_sequencer #(
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pCAPTURE_LEN_WIDTH    = 24
) (
  input  logic                          fe_clk,
  input  logic                          reset_n,
  input  logic                          I_arm,
  input  logic                          I_trigger,
  input  logic [pCAPTURE_LEN_WIDTH-1:0] I_capture_len,
  input  logic                          I_event,
  input  logic [1:0]                    I_data_cmd,
  input  logic [15:0]                   I_max_short_timestamp,
  fe_capture_sequencer_if.master        fifo,
  output logic                          O_capturing,
  output logic                          O_capture_done,
  output logic                          O_overflow,
  output logic [pCAPTURE_LEN_WIDTH-1:0] O_entries
);
  localparam int TW = pTIMESTAMP_FULL_WIDTH;
  localparam int CW = pCAPTURE_LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state_q, state_d;

  logic [TW-1:0] dcnt_q, delta;
  logic          trig_now, in_cap, accept, is_long, sat;

  // one-stage holding register for the event entry (fixed latency 2)
  logic          ev_vld_q;
  logic [1:0]    ev_cmd_q;
  logic [TW-1:0] ev_time_q;

  logic          wr_req, wr_ok, lost, hit_len;
  logic [1:0]    wr_cmd;
  logic [TW-1:0] wr_time;
  logic [CW-1:0] entries_inc;

  logic          wr_q, ovf_q;
  logic [1:0]    cmd_q;
  logic [TW-1:0] time_q;
  logic [CW-1:0] entries_q;

  // Event acceptance, delta classification and write selection for this cycle.
  // I_fifo_full is sampled in the cycle that decides a write, since the write
  // strobe is registered. A held event entry wins over a TIME entry; the two
  // never coincide as long as I_max_short_timestamp >= 1.
  always_comb begin
    trig_now    = (state_q == ARMED) && I_arm && I_trigger;
    in_cap      = (state_q == CAPTURE) && I_arm;
    accept      = (trig_now || in_cap) && I_event;
    delta       = trig_now ? '0 : dcnt_q;
    is_long     = accept && ({16'd0, delta} > {{TW{1'b0}}, I_max_short_timestamp});
    sat         = in_cap && !I_event && (delta == {TW{1'b1}});
    wr_req      = 1'b0;
    wr_cmd      = ev_cmd_q;
    wr_time     = ev_time_q;
    if (in_cap && ev_vld_q) begin
      wr_req = 1'b1;
    end else if (in_cap && (is_long || sat)) begin
      wr_req  = 1'b1;
      wr_cmd  = `FE_FIFO_CMD_TIME;
      wr_time = delta;
    end
    wr_ok       = wr_req && !fifo.fifo_full;
    lost        = wr_req && fifo.fifo_full;
    entries_inc = entries_q + 1'b1;
    hit_len     = wr_ok && (I_capture_len != '0) && (entries_inc == I_capture_len);
  end

  // Next-state logic; dropping I_arm aborts from any state.
  always_comb begin
    state_d = state_q;
    if (!I_arm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (I_trigger) state_d = CAPTURE;
        CAPTURE: if (lost || hit_len) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Delta counter holds the delta of the next cycle; every reference cycle restarts it.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n)     dcnt_q <= '0;
    else if (trig_now) dcnt_q <= TW'(1);
    else if (in_cap)  dcnt_q <= (accept || sat) ? TW'(1) : dcnt_q + 1'b1;
  end

  // Event stage; cleared whenever the capture ends so in-flight entries vanish.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_vld_q  <= 1'b0;
      ev_cmd_q  <= '0;
      ev_time_q <= '0;
    end else begin
      ev_vld_q <= accept && (state_d == CAPTURE);
      if (accept) begin
        ev_cmd_q  <= I_data_cmd;
        ev_time_q <= is_long ? '0 : delta;
      end
    end
  end

  // Registered FIFO write; command/time hold between writes.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= 1'b0;
      cmd_q  <= '0;
      time_q <= '0;
    end else begin
      wr_q <= wr_ok;
      if (wr_ok) begin
        cmd_q  <= wr_cmd;
        time_q <= wr_time;
      end
    end
  end

  // Entry count and sticky overflow, both cleared when a new capture is armed.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      entries_q <= '0;
      ovf_q     <= 1'b0;
    end else if (state_q == IDLE && I_arm) begin
      entries_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_ok) entries_q <= entries_inc;
      if (lost)  ovf_q     <= 1'b1;
    end
  end

  assign fifo.fifo_wr      = wr_q;
  assign fifo.fifo_command = cmd_q;
  assign fifo.fifo_time    = time_q;
  assign O_capturing       = (state_q == CAPTURE);
  assign O_capture_done    = (state_q == DONE);
  assign O_overflow        = ovf_q;
  assign O_entries         = entries_q;
endmodule

// File: tb/tb_fe_capture_sequencer.sv
// Bench for fe_capture_sequencer: directed scenarios plus random captures,
// each checked against a cycle-indexed schedule of expected FIFO writes.
`ifndef FE_FIFO_CMD_DATA
`define FE_FIFO_CMD_DATA 2'b00
`define FE_FIFO_CMD_STAT 2'b01
`define FE_FIFO_CMD_TIME 2'b10
`endif

module tb_fe_capture_sequencer;
  localparam int W    = 8;
  localparam int L    = 24;
  localparam int MAXV = (1 << W) - 1;
  localparam int NMAX = 300;

  logic         fe_clk = 1'b0;
  logic         reset_n;
  logic         I_arm, I_trigger, I_event;
  logic [L-1:0] I_capture_len;
  logic [1:0]   I_data_cmd;
  logic [15:0]  I_max_short_timestamp;
  logic         O_capturing, O_capture_done, O_overflow;
  logic [L-1:0] O_entries;

  fe_capture_sequencer_if #(.pTIMESTAMP_FULL_WIDTH(W)) fifo_bus ();

  fe_capture_sequencer #(.pTIMESTAMP_FULL_WIDTH(W), .pCAPTURE_LEN_WIDTH(L)) dut (
    .fe_clk(fe_clk), .reset_n(reset_n), .I_arm(I_arm), .I_trigger(I_trigger),
    .I_capture_len(I_capture_len), .I_event(I_event), .I_data_cmd(I_data_cmd),
    .I_max_short_timestamp(I_max_short_timestamp), .fifo(fifo_bus),
    .O_capturing(O_capturing), .O_capture_done(O_capture_done),
    .O_overflow(O_overflow), .O_entries(O_entries)
  );

  always #5 fe_clk = ~fe_clk;

  int checks = 0;
  int errors = 0;

  // stimulus per cycle offset from the trigger (offset 0 = trigger cycle)
  bit         ev[NMAX];
  logic [1:0] cm[NMAX];
  bit         fl[NMAX];
  // raw schedule of entries, then what survives length/overflow accounting
  bit         sch_v[NMAX];
  logic [1:0] ex_c[NMAX];
  int         ex_t[NMAX];
  bit         wr_e[NMAX];
  int         m_entries;
  bit         m_ovf, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      ev[i] = 0; cm[i] = `FE_FIFO_CMD_DATA; fl[i] = 0;
    end
  endtask

  task automatic put(input int o, input logic [1:0] c, input int t);
    sch_v[o] = 1; ex_c[o] = c; ex_t[o] = t;
  endtask

  // Reference: timestamps from the distance to the last reference cycle,
  // then a walk over the resulting write slots for length/overflow limits.
  task automatic model(input int n, input int ms, input int len);
    int ref_c, d;
    for (int i = 0; i < NMAX; i++) begin sch_v[i] = 0; wr_e[i] = 0; ex_c[i] = 0; ex_t[i] = 0; end
    ref_c = 0;
    for (int c = 0; c <= n + 3; c++) begin
      d = c - ref_c;
      if (ev[c]) begin
        if (d > ms) begin
          put(c + 1, `FE_FIFO_CMD_TIME, d);
          put(c + 2, cm[c], 0);
        end else begin
          put(c + 2, cm[c], d);
        end
        ref_c = c;
      end else if (d == MAXV) begin
        put(c + 1, `FE_FIFO_CMD_TIME, MAXV);
        ref_c = c;
      end
    end
    m_entries = 0; m_ovf = 0; m_done = 0;
    for (int o = 1; o <= n + 4; o++) begin
      if (sch_v[o] && !m_done) begin
        if (fl[o-1]) begin
          m_ovf = 1; m_done = 1;
        end else begin
          wr_e[o] = 1;
          m_entries++;
          if (len != 0 && m_entries == len) m_done = 1;
        end
      end
    end
  endtask

  // Arm, trigger at offset 0, play the stimulus and compare every cycle.
  task automatic run(input string tag, input int n, input int ms, input int len);
    model(n, ms, len);
    I_max_short_timestamp = 16'(ms);
    I_capture_len = L'(len);
    I_arm = 0; I_trigger = 0; I_event = 0; fifo_bus.fifo_full = 0;
    tick(); tick();
    I_arm = 1;
    tick();
    check({tag, ".armed_entries"}, O_entries, 0);
    check({tag, ".armed_ovf"}, O_overflow, 0);
    check({tag, ".armed_cap"}, O_capturing, 0);
    for (int c = 0; c <= n + 4; c++) begin
      if (c > 0) begin
        check($sformatf("%s.wr@%0d", tag, c), fifo_bus.fifo_wr, wr_e[c]);
        if (wr_e[c]) begin
          check($sformatf("%s.cmd@%0d", tag, c), fifo_bus.fifo_command, ex_c[c]);
          check($sformatf("%s.time@%0d", tag, c), fifo_bus.fifo_time, ex_t[c]);
        end
      end
      if (c == n + 4) break;
      I_trigger  = (c == 0);
      I_event    = (c < n) ? ev[c] : 1'b0;
      I_data_cmd = cm[c];
      fifo_bus.fifo_full = fl[c];
      tick();
    end
    I_trigger = 0; I_event = 0; fifo_bus.fifo_full = 0;
    check({tag, ".entries"}, O_entries, m_entries);
    check({tag, ".done"}, O_capture_done, m_done);
    check({tag, ".ovf"}, O_overflow, m_ovf);
    check({tag, ".capturing"}, O_capturing, !m_done);
  endtask

  initial begin
    int n, ms, len, pden;
    reset_n = 0; I_arm = 0; I_trigger = 0; I_event = 0; I_data_cmd = 0;
    I_capture_len = 0; I_max_short_timestamp = 7; fifo_bus.fifo_full = 0;
    #12;
    check("rst.wr", fifo_bus.fifo_wr, 0);
    check("rst.cmd", fifo_bus.fifo_command, 0);
    check("rst.time", fifo_bus.fifo_time, 0);
    check("rst.cap", O_capturing, 0);
    check("rst.done", O_capture_done, 0);
    check("rst.ovf", O_overflow, 0);
    check("rst.entries", O_entries, 0);
    #5 reset_n = 1;

    // short events, then a long gap with TIME insertion, then back-to-back
    clear_stim();
    ev[3] = 1; cm[3] = `FE_FIFO_CMD_DATA;
    ev[4] = 1; cm[4] = `FE_FIFO_CMD_STAT;
    ev[20] = 1; cm[20] = `FE_FIFO_CMD_DATA;
    ev[21] = 1; cm[21] = `FE_FIFO_CMD_STAT;
    run("basic", 30, 7, 0);

    // saturation with no events, then a short event after the saturation point
    clear_stim();
    ev[260] = 1; cm[260] = `FE_FIFO_CMD_STAT;
    run("sat", 270, 7, 0);

    // event landing exactly on the saturation delta is a long event
    clear_stim();
    ev[255] = 1; cm[255] = `FE_FIFO_CMD_DATA;
    run("sat_ev", 262, 7, 0);

    // length limit reached by consecutive short events
    clear_stim();
    for (int i = 1; i <= 5; i++) begin ev[i] = 1; cm[i] = 2'(i & 1); end
    run("len3", 10, 7, 3);

    // length 1 with a long event: only the TIME half goes out
    clear_stim();
    ev[10] = 1;
    run("len1_long", 15, 7, 1);

    // max_short beyond the delta range: no TIME entries for events
    clear_stim();
    ev[100] = 1; ev[200] = 1; cm[200] = `FE_FIFO_CMD_STAT;
    run("wide_short", 210, 300, 0);

    // FIFO full during the second event's write
    clear_stim();
    ev[3] = 1; ev[4] = 1; cm[4] = `FE_FIFO_CMD_STAT;
    fl[5] = 1;
    run("ovf", 10, 7, 0);
    I_arm = 0; tick();
    I_arm = 1; tick();
    check("ovf_clear", O_overflow, 0);
    check("ovf_entries_clear", O_entries, 0);

    // random captures
    for (int r = 0; r < 8; r++) begin
      clear_stim();
      n    = $urandom_range(40, 280);
      ms   = $urandom_range(1, 20);
      len  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
      pden = (r % 3 == 0) ? 2 : ((r % 3 == 1) ? 8 : 64);
      for (int c = 0; c < n; c++) begin
        ev[c] = ($urandom_range(0, pden - 1) == 0);
        cm[c] = $urandom_range(0, 1) ? `FE_FIFO_CMD_STAT : `FE_FIFO_CMD_DATA;
      end
      if (r % 2 == 1)
        for (int c = 0; c < n + 4; c++) fl[c] = ($urandom_range(0, 149) == 0);
      run($sformatf("rnd%0d", r), n, ms, len);
    end

    // asynchronous reset with entries in flight
    I_arm = 0; I_capture_len = 0; I_max_short_timestamp = 7;
    tick(); tick();
    I_arm = 1; tick();
    I_trigger = 1; tick();
    I_trigger = 0; I_event = 1; I_data_cmd = `FE_FIFO_CMD_STAT; tick();
    I_data_cmd = `FE_FIFO_CMD_DATA; tick();
    I_event = 0;
    check("mid.wr_before", fifo_bus.fifo_wr, 1);
    check("mid.time_before", fifo_bus.fifo_time, 1);
    #2 reset_n = 0;
    #1;
    check("mid.wr", fifo_bus.fifo_wr, 0);
    check("mid.cmd", fifo_bus.fifo_command, 0);
    check("mid.time", fifo_bus.fifo_time, 0);
    check("mid.cap", O_capturing, 0);
    check("mid.entries", O_entries, 0);
    tick();
    #3 reset_n = 1;
    check("mid.cap_rel", O_capturing, 0);
    check("mid.done_rel", O_capture_done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid.no_wr%0d", i), fifo_bus.fifo_wr, 0);
    end

    // trigger while IDLE is ignored (arm low, and arm rising with trigger)
    I_arm = 0; tick(); tick();
    I_trigger = 1; I_event = 1; tick();
    check("idle_trig.cap0", O_capturing, 0);
    I_arm = 1; tick();
    I_trigger = 0; I_event = 0;
    check("idle_trig.cap1", O_capturing, 0);
    tick();
    check("idle_trig.cap2", O_capturing, 0);
    tick(); tick();
    check("idle_trig.wr", fifo_bus.fifo_wr, 0);
    check("idle_trig.entries", O_entries, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
